// File: rtl/alu_seq_exec.sv
// Sequential ALU: single-cycle logic/arith, serial one-bit-per-cycle shifts, iterative shift-add MUL (ALU_MUL_EN).
// Latency: 1 cycle for logic/arith/illegal, shift_amt+1 for shifts (1 if shift_amt==0), WIDTH+1 for MUL.
// Backpressure: in_ready only in IDLE; the result is held in DONE, with out_valid high, until out_ready.
module alu_seq_exec #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       func,
    input  logic [4:0]       shift_amt,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);
    localparam logic [5:0] F_ADD = 6'h00;
    localparam logic [5:0] F_SUB = 6'h01;
    localparam logic [5:0] F_AND = 6'h02;
    localparam logic [5:0] F_OR  = 6'h03;
    localparam logic [5:0] F_XOR = 6'h04;
    localparam logic [5:0] F_NOR = 6'h05;
    localparam logic [5:0] F_SLT = 6'h06;
    localparam logic [5:0] F_SLL = 6'h10;
    localparam logic [5:0] F_SRL = 6'h11;
    localparam logic [5:0] F_SRA = 6'h12;
    localparam logic [5:0] F_MUL = 6'h18;
    // Counter must hold both shift_amt (up to 31) and WIDTH (up to 32).
    localparam int CW = 6;

`ifdef ALU_MUL_EN
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, MUL} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
`endif

    state_t           state;
    logic [5:0]       func_q;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] work;      // shift source, or multiplicand during MUL
    logic [WIDTH-1:0] alu_res;
    logic             alu_ill;
    logic             is_shift;
    logic [WIDTH-1:0] sh_next;
`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc_next;
`endif

    // Single-cycle result; shifts with shift_amt==0 pass op_a straight through.
    always_comb begin
        alu_res = '0;
        alu_ill = 1'b0;
        case (func)
            F_ADD:               alu_res = op_a + op_b;
            F_SUB:               alu_res = op_a - op_b;
            F_AND:               alu_res = op_a & op_b;
            F_OR:                alu_res = op_a | op_b;
            F_XOR:               alu_res = op_a ^ op_b;
            F_NOR:               alu_res = ~(op_a | op_b);
            F_SLT:               alu_res = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            F_SLL, F_SRL, F_SRA: alu_res = op_a;
`ifdef ALU_MUL_EN
            F_MUL:               alu_res = '0;
`endif
            default:             alu_ill = 1'b1;
        endcase
    end

    // Decode which requests take the serial shift path.
    always_comb begin
        is_shift = (func == F_SLL) || (func == F_SRL) || (func == F_SRA);
    end

    // One-bit shift step for the op in flight; SRA replicates the sign bit.
    always_comb begin
        sh_next = work;
        case (func_q)
            F_SLL:   sh_next = {work[WIDTH-2:0], 1'b0};
            F_SRL:   sh_next = {1'b0, work[WIDTH-1:1]};
            default: sh_next = {work[WIDTH-1], work[WIDTH-1:1]};
        endcase
    end

`ifdef ALU_MUL_EN
    // Shift-add step: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_next = acc + (mplier[0] ? work : '0);
    end
`endif

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            illegal   <= 1'b0;
            func_q    <= '0;
            cnt       <= '0;
            work      <= '0;
`ifdef ALU_MUL_EN
            acc       <= '0;
            mplier    <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        func_q   <= func;
                        work     <= op_a;
                        in_ready <= 1'b0;
                        if (is_shift && (shift_amt != 5'd0)) begin
                            state <= SHIFT;
                            cnt   <= CW'(shift_amt);
`ifdef ALU_MUL_EN
                        end else if (func == F_MUL) begin
                            state  <= MUL;
                            cnt    <= CW'(WIDTH);
                            acc    <= '0;
                            mplier <= op_b;
`endif
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            illegal   <= alu_ill;
                        end
                    end
                end
                SHIFT: begin
                    work <= sh_next;
                    cnt  <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= sh_next;
                        zero      <= (sh_next == '0);
                        illegal   <= 1'b0;
                    end
                end
`ifdef ALU_MUL_EN
                MUL: begin
                    acc    <= acc_next;
                    work   <= {work[WIDTH-2:0], 1'b0};
                    mplier <= mplier >> 1;
                    cnt    <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        result    <= acc_next;
                        zero      <= (acc_next == '0);
                        illegal   <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_alu_seq_exec.sv
// Randomized + directed bench for alu_seq_exec against an arithmetic reference model.
// Checks result, zero, illegal, latency, hold under backpressure and async abort.
// Drives inputs on the falling edge, samples outputs 1 time unit after the rising edge.
module tb_alu_seq_exec;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [5:0]   func;
    logic [4:0]   shift_amt;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         illegal;

    int total = 0;
    int bad   = 0;

    alu_seq_exec #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .func      (func),
        .shift_amt (shift_amt),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: value, illegal flag and cycles from accept to out_valid.
    function automatic void model(input logic [5:0] f, input logic [4:0] s,
                                  input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] r, output logic il, output int lat);
        r   = '0;
        il  = 1'b0;
        lat = 1;
        case (f)
            6'h00: r = a + b;
            6'h01: r = a - b;
            6'h02: r = a & b;
            6'h03: r = a | b;
            6'h04: r = a ^ b;
            6'h05: r = ~(a | b);
            6'h06: r = ($signed(a) < $signed(b)) ? 1 : 0;
            6'h10: begin r = (int'(s) >= W) ? '0 : (a << s); lat = (s == 0) ? 1 : int'(s) + 1; end
            6'h11: begin r = (int'(s) >= W) ? '0 : (a >> s); lat = (s == 0) ? 1 : int'(s) + 1; end
            6'h12: begin
                r   = (int'(s) >= W) ? {W{a[W-1]}} : W'($signed(a) >>> s);
                lat = (s == 0) ? 1 : int'(s) + 1;
            end
`ifdef ALU_MUL_EN
            6'h18: begin r = a * b; lat = W + 1; end
`endif
            default: il = 1'b1;
        endcase
    endfunction

    // Issue one op, check latency/outputs, hold for 'hold' cycles under backpressure, then drain.
    task automatic run_op(input string tag, input logic [5:0] f, input logic [4:0] s,
                          input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
        logic [W-1:0] er;
        logic         eil;
        int           elat;
        int           n;
        int           lat;
        model(f, s, a, b, er, eil, elat);
        @(negedge clk);
        in_valid = 1'b1; func = f; shift_amt = s; op_a = a; op_b = b;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        if (!in_ready) chk({tag, "_accept_timeout"}, 1, 0);
        @(posedge clk); #1;
        // Scramble inputs after accept: the op in flight must not see them.
        in_valid  = 1'b0;
        func      = 6'($urandom);
        shift_amt = 5'($urandom);
        op_a      = $urandom;
        op_b      = $urandom;
        lat = 1;
        while (!out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_res"}, 64'(result), 64'(er));
        chk({tag, "_zero"}, 64'(zero), 64'(er == '0));
        chk({tag, "_ill"}, 64'(illegal), 64'(eil));
        chk({tag, "_inrdy_busy"}, 64'(in_ready), 0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({tag, "_hold_vld"}, 64'(out_valid), 1);
            chk({tag, "_hold_res"}, 64'(result), 64'(er));
            chk({tag, "_hold_inrdy"}, 64'(in_ready), 0);
        end
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1;
        chk({tag, "_drain_vld"}, 64'(out_valid), 0);
        chk({tag, "_drain_inrdy"}, 64'(in_ready), 1);
        out_ready = 1'b0;
    endtask

    logic [5:0] codes [11] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05,
                               6'h06, 6'h10, 6'h11, 6'h12, 6'h18};

    initial begin
        bit           saw;
        logic [5:0]   f;
        logic [W-1:0] a;
        logic [W-1:0] b;
        int           k;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        func = '0; shift_amt = '0; op_a = '0; op_b = '0;
        #12;
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_result", 64'(result), 0);
        chk("rst_zero", 64'(zero), 0);
        chk("rst_illegal", 64'(illegal), 0);
        @(negedge clk); rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_out_valid", 64'(out_valid), 0);
        chk("idle_in_ready", 64'(in_ready), 1);

        run_op("add_wrap", 6'h00, 5'd0, 32'hFFFF_FFFF, 32'd1, 0);
        run_op("slt_neg", 6'h06, 5'd0, 32'h8000_0000, 32'd1, 1);
        run_op("sub_eq", 6'h01, 5'd0, 32'd5, 32'd5, 0);
        run_op("sra4", 6'h12, 5'd4, 32'h8000_0000, 32'd0, 0);
        run_op("sra0", 6'h12, 5'd0, 32'h8000_0000, 32'd0, 0);
        run_op("sll31", 6'h10, 5'd31, 32'h0000_0003, 32'd0, 0);
        run_op("srl1", 6'h11, 5'd1, 32'hF000_0001, 32'd0, 0);
        run_op("mul7x6", 6'h18, 5'd0, 32'd7, 32'd6, 0);
        run_op("ill3f", 6'h3F, 5'd0, 32'h1234_5678, 32'd9, 0);
        run_op("nor_bp", 6'h05, 5'd0, 32'h0F0F_0000, 32'h0000_00FF, 10);

        // Abort a long shift with an async reset pulse; no result may follow.
        @(negedge clk);
        in_valid = 1'b1; func = 6'h10; shift_amt = 5'd20; op_a = 32'h1; op_b = '0;
        @(negedge clk); in_valid = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("abort_out_valid", 64'(out_valid), 0);
        chk("abort_in_ready", 64'(in_ready), 1);
        @(negedge clk); rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (out_valid) saw = 1'b1;
        end
        chk("abort_no_result", 64'(saw), 0);
        chk("abort_idle", 64'(in_ready), 1);

        for (int i = 0; i < 250; i++) begin
            k = $urandom_range(0, 11);
            f = (k == 11) ? 6'($urandom) : codes[k];
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = a;
                1: a = '0;
                2: b = a + 1;
                default: ;
            endcase
            run_op("rnd", f, 5'($urandom), a, b, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
